mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit that produces the mul_div_low / mul_div_upper results consumed by the integer ALU result path.
- Accepts one operation per Start pulse and computes it over a fixed number of cycles: radix-2 shift-add multiply, or restoring divide.
- Signals completion with a one-cycle Done pulse. Control logic stalls the core while Busy is high.

Parameters:
- DWIDTH, 32, operand and result width in bits (must be even, ≥ 4).

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- MD_Start  input  1  start request; sampled only in IDLE.
- MD_Flush  input  1  synchronous abort; returns the unit to IDLE with no Done.
- MD_OP  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- MD_In_A  input  DWIDTH  operand A: rs1 / dividend.
- MD_In_B  input  DWIDTH  operand B: rs2 / divisor.
- MD_Result  output  DWIDTH  selected architectural result.
- MD_Low  output  DWIDTH  low product word, or quotient.
- MD_Upper  output  DWIDTH  high product word, or remainder.
- MD_Busy  output  1  operation in progress.
- MD_Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: state = IDLE; MD_Result, MD_Low, MD_Upper = 0; MD_Busy = 0; MD_Done = 0; all internal registers = 0.
- States:
  - IDLE: MD_Start=1 latches OP, A, B, their operand signs and the absolute-value operands. Goes to CALC with counter = 0 and MD_Busy = 1 from the next cycle.
  - CALC: one iteration per cycle for exactly DWIDTH cycles. Counter wraps at DWIDTH-1, then goes to FINISH.
  - FINISH: applies sign correction and registers MD_Low, MD_Upper and MD_Result. Asserts MD_Done = 1 for this cycle only, deasserts MD_Busy, then returns to IDLE.
- Latency: if MD_Start is sampled at edge T, MD_Done is high in the cycle after edge T+DWIDTH+1, i.e. DWIDTH+2 cycles from request. This latency is constant for all ops, including special cases.
- Result outputs hold their value until the next FINISH or Reset.
- Multiply: uses a 2·DWIDTH unsigned product of |A| and |B|, then negates the full product if the operand signs differ.
  - Signed/unsigned interpretation: MUL/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - MD_Low = product[DWIDTH-1:0]; MD_Upper = product[2·DWIDTH-1:DWIDTH].
  - MD_Result = MD_Low for MUL; MD_Result = MD_Upper for MULH, MULHSU and MULHU.
- Divide: restoring divide on |A| / |B| for the signed ops; raw operands for the unsigned ops.
  - Quotient sign = sign(A) xor sign(B). Remainder takes the sign of A.
  - MD_Low = quotient; MD_Upper = remainder.
  - MD_Result = quotient for DIV/DIVU; MD_Result = remainder for REM/REMU.
- Divide by zero (B = 0): quotient = all ones; remainder = A. This applies to both signed and unsigned ops, with the same latency.
- Signed overflow (A = 2^(DWIDTH-1), B = all ones, DIV/REM): quotient = A; remainder = 0.
- MD_Start while Busy: ignored. There is no queueing, and operands are not re-latched.
- MD_Start and MD_Flush in the same IDLE cycle: Flush wins and the unit stays in IDLE.
- MD_Flush in CALC or FINISH: goes to IDLE next cycle with MD_Busy = 0 and no MD_Done. Result registers keep their previous values.
- Reset mid-operation: immediate return to IDLE with all outputs at 0. No Done pulse follows.
- Operands are captured at Start. Changes to MD_In_A, MD_In_B or MD_OP during CALC have no effect.

Decomposition:
- Shared package additions to defines.vh:
  - MD_OP encodings: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (3-bit).
  - State encodings: MD_IDLE, MD_CALC, MD_FINISH.
- Sub-module md_iter_core: holds the per-cycle shift-add / restore-subtract step and the iteration counter.
- Sign handling, special cases and output muxing stay in mul_div_unit.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> after 34 cycles Done pulses once; MD_Result=0xFFFFFFEB; MD_Upper=0xFFFFFFFF; Busy high for exactly 33 cycles.
- MULHU A=B=0xFFFFFFFF -> MD_Result=0xFFFFFFFE, MD_Low=0x00000001. MULHSU A=0xFFFFFFFF, B=2 -> MD_Result=0xFFFFFFFF.
- DIV A=-20, B=3 -> quotient 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU A=20, B=3 -> 6.
- DIV A=5, B=0 -> MD_Result=0xFFFFFFFF. REMU A=5, B=0 -> 5. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Start pulsed again mid-CALC with new operands -> ignored; original result delivered at the original cycle.
- Flush asserted at CALC cycle 10 -> Busy low next cycle, no Done, results unchanged. Reset asserted mid-CALC (async, between edges) -> all outputs 0 immediately; new Start after release completes normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 operation
// codes, controller states and operand-signedness helpers.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  function automatic logic op_signed_a(input md_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_signed_b(input md_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One radix-2 iteration per step: shift-add multiply of unsigned operands, or
// restoring divide. hi/lo hold {accumulator, multiplier} or {remainder, quotient}.
module md_iter_core #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DWIDTH-1:0] a_in,
  input  logic [DWIDTH-1:0] b_in,
  output logic [DWIDTH-1:0] hi,
  output logic [DWIDTH-1:0] lo,
  output logic              last
);

  localparam int CW = $clog2(DWIDTH);

  logic [DWIDTH-1:0] b_reg;
  logic [CW-1:0]     cnt;
  logic [DWIDTH:0]   add_sum;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH-1:0] hi_n;
  logic [DWIDTH-1:0] lo_n;

  assign last = step && (cnt == CW'(DWIDTH - 1));

  always_comb begin
    add_sum = {1'b0, hi} + {1'b0, b_reg};
    shifted = {hi, lo[DWIDTH-1]};
    // Remainder stays below the divisor, so shifted < 2*divisor and bit DWIDTH of
    // the difference is a reliable borrow flag.
    diff    = shifted - {1'b0, b_reg};
    hi_n    = hi;
    lo_n    = lo;
    if (is_div) begin
      if (!diff[DWIDTH]) begin
        hi_n = diff[DWIDTH-1:0];
        lo_n = {lo[DWIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[DWIDTH-1:0];
        lo_n = {lo[DWIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_n = add_sum[DWIDTH:1];
      lo_n = {add_sum[0], lo[DWIDTH-1:1]};
    end else begin
      hi_n = {1'b0, hi[DWIDTH-1:1]};
      lo_n = {hi[0], lo[DWIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a_in;
      b_reg <= b_in;
      cnt   <= '0;
    end else if (step) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (DWIDTH steps) -> FINISH,
// with sign fix-up, divide special cases and result muxing applied in FINISH.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MD_Start,
  input  logic              MD_Flush,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  output logic [DWIDTH-1:0] MD_Result,
  output logic [DWIDTH-1:0] MD_Low,
  output logic [DWIDTH-1:0] MD_Upper,
  output logic              MD_Busy,
  output logic              MD_Done,
  output md_state_e         md_state
);

  localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  md_state_e         state;
  md_op_e            op_q;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic              sign_a_q;
  logic              sign_b_q;

  md_op_e            op_in;
  logic              in_sign_a;
  logic              in_sign_b;
  logic [DWIDTH-1:0] abs_a;
  logic [DWIDTH-1:0] abs_b;
  logic              load;
  logic              step;
  logic              core_last;
  logic [DWIDTH-1:0] core_hi;
  logic [DWIDTH-1:0] core_lo;

  logic [2*DWIDTH-1:0] prod_fix;
  logic [DWIDTH-1:0]   quo_fix;
  logic [DWIDTH-1:0]   rem_fix;
  logic [DWIDTH-1:0]   low_n;
  logic [DWIDTH-1:0]   upper_n;
  logic [DWIDTH-1:0]   result_n;

  assign md_state = state;

  always_comb begin
    op_in     = md_op_e'(MD_OP);
    in_sign_a = op_signed_a(op_in) & MD_In_A[DWIDTH-1];
    in_sign_b = op_signed_b(op_in) & MD_In_B[DWIDTH-1];
    abs_a     = in_sign_a ? -MD_In_A : MD_In_A;
    abs_b     = in_sign_b ? -MD_In_B : MD_In_B;
    load      = (state == MD_IDLE) && MD_Start && !MD_Flush;
    step      = (state == MD_CALC) && !MD_Flush;
  end

  md_iter_core #(.DWIDTH(DWIDTH)) u_core (
    .clk    (Clk),
    .rst    (Reset),
    .load   (load),
    .step   (step),
    .is_div (op_q[2]),
    .a_in   (abs_a),
    .b_in   (abs_b),
    .hi     (core_hi),
    .lo     (core_lo),
    .last   (core_last)
  );

  // Fix-up of the unsigned core results; evaluated every cycle, registered in FINISH.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
    rem_fix  = sign_a_q ? -core_hi : core_hi;
    if (b_q == '0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if ((op_q inside {DIV, REM}) && (a_q == MIN_NEG) && (&b_q)) begin
      quo_fix = a_q;
      rem_fix = '0;
    end

    if (op_q[2]) begin
      low_n   = quo_fix;
      upper_n = rem_fix;
    end else begin
      low_n   = prod_fix[DWIDTH-1:0];
      upper_n = prod_fix[2*DWIDTH-1:DWIDTH];
    end

    case (op_q)
      MUL:        result_n = low_n;
      DIV, DIVU:  result_n = quo_fix;
      REM, REMU:  result_n = rem_fix;
      default:    result_n = upper_n;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= MD_IDLE;
      op_q      <= MUL;
      a_q       <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      MD_Result <= '0;
      MD_Low    <= '0;
      MD_Upper  <= '0;
      MD_Busy   <= 1'b0;
      MD_Done   <= 1'b0;
    end else begin
      MD_Done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (load) begin
            op_q     <= op_in;
            a_q      <= MD_In_A;
            b_q      <= MD_In_B;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            MD_Busy  <= 1'b1;
            state    <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (MD_Flush) begin
            MD_Busy <= 1'b0;
            state   <= MD_IDLE;
          end else if (core_last) begin
            state <= MD_FINISH;
          end
        end
        MD_FINISH: begin
          if (!MD_Flush) begin
            MD_Low    <= low_n;
            MD_Upper  <= upper_n;
            MD_Result <= result_n;
            MD_Done   <= 1'b1;
          end
          MD_Busy <= 1'b0;
          state   <= MD_IDLE;
        end
        default: begin
          MD_Busy <= 1'b0;
          state   <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: the driver pushes hand-computed results into
// expected queues, a negedge monitor pops and compares on every Done pulse.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         md_start;
  logic         md_flush;
  logic [2:0]   md_op;
  logic [W-1:0] md_a;
  logic [W-1:0] md_b;
  logic [W-1:0] md_result;
  logic [W-1:0] md_low;
  logic [W-1:0] md_upper;
  logic         md_busy;
  logic         md_done;
  md_state_e    dut_state;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;

  logic [W-1:0] exp_res_q[$];
  logic [W-1:0] exp_low_q[$];
  logic [W-1:0] exp_up_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] last_res, last_low, last_up;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] low;
    logic [W-1:0] up;
  } vec_t;

  vec_t vecs[15];

  mul_div_unit #(.DWIDTH(W)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .MD_Start  (md_start),
    .MD_Flush  (md_flush),
    .MD_OP     (md_op),
    .MD_In_A   (md_a),
    .MD_In_B   (md_b),
    .MD_Result (md_result),
    .MD_Low    (md_low),
    .MD_Upper  (md_upper),
    .MD_Busy   (md_busy),
    .MD_Done   (md_done),
    .md_state  (dut_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && md_done) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_done", 32'(md_done), 32'd0);
      end else begin
        check("result", md_result, exp_res_q.pop_front());
        check("low", md_low, exp_low_q.pop_front());
        check("upper", md_upper, exp_up_q.pop_front());
        check("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  // mode: 0 normal, 1 Start re-pulsed mid-CALC, 2 Flush at CALC cycle 10, 3 async Reset mid-CALC
  task automatic run_op(input vec_t v, input int mode);
    int busy_cnt;
    int i;
    @(negedge clk);
    md_op    = v.op;
    md_a     = v.a;
    md_b     = v.b;
    md_start = 1'b1;
    if (mode < 2) begin
      exp_res_q.push_back(v.res);
      exp_low_q.push_back(v.low);
      exp_up_q.push_back(v.up);
      exp_cyc_q.push_back(cyc + 1 + W + 1);
      last_res = v.res;
      last_low = v.low;
      last_up  = v.up;
    end
    @(negedge clk);
    md_start = 1'b0;
    md_a     = $urandom;
    md_b     = $urandom;
    md_op    = 3'($urandom_range(0, 7));
    busy_cnt = 0;
    i        = 0;
    while (md_busy && i < W + 20) begin
      busy_cnt++;
      if (mode == 1) md_start = (i == 5);
      if (mode == 2 && i == 10) md_flush = 1'b1;
      if (mode == 3 && i == 7) begin
        #3 rst = 1'b1;
        #1;
        check("rst_result", md_result, '0);
        check("rst_low", md_low, '0);
        check("rst_upper", md_upper, '0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_done", 32'(md_done), 32'd0);
        check("rst_state", 32'(dut_state), 32'(MD_IDLE));
      end
      @(negedge clk);
      md_start = 1'b0;
      md_flush = 1'b0;
      i++;
    end
    case (mode)
      0, 1: check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
      2: begin
        check("flush_busy_cycles", 32'(busy_cnt), 32'd11);
        check("flush_keep_result", md_result, last_res);
        check("flush_keep_low", md_low, last_low);
        check("flush_keep_upper", md_upper, last_up);
        repeat (W + 4) @(negedge clk);
        check("flush_stays_idle", 32'(md_busy), 32'd0);
      end
      default: begin
        check("rst_busy_cycles", 32'(busy_cnt), 32'd8);
        rst = 1'b0;
        last_res = '0;
        last_low = '0;
        last_up  = '0;
        repeat (W + 4) @(negedge clk);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[3]  = '{DIV,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFE};
    vecs[4]  = '{REM,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'hFFFFFFFE};
    vecs[5]  = '{DIVU,   32'h00000014, 32'h00000003, 32'h00000006, 32'h00000006, 32'h00000002};
    vecs[6]  = '{DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005};
    vecs[7]  = '{REMU,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32'h00000005};
    vecs[8]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[9]  = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[10] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000};
    vecs[11] = '{DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[12] = '{MUL,    32'h12345678, 32'h00000010, 32'h23456780, 32'h23456780, 32'h00000001};
    vecs[13] = '{DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h0000000F};
    vecs[14] = '{REM,    32'h00000014, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFA, 32'h00000002};

    rst      = 1'b1;
    md_start = 1'b0;
    md_flush = 1'b0;
    md_op    = '0;
    md_a     = '0;
    md_b     = '0;
    last_res = '0;
    last_low = '0;
    last_up  = '0;
    repeat (3) @(negedge clk);
    check("reset_result", md_result, '0);
    check("reset_low", md_low, '0);
    check("reset_upper", md_upper, '0);
    check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_done", 32'(md_done), 32'd0);
    check("reset_state", 32'(dut_state), 32'(MD_IDLE));
    rst = 1'b0;

    foreach (vecs[k]) run_op(vecs[k], 0);

    run_op(vecs[3], 1);
    run_op(vecs[13], 2);

    // Start and Flush together in IDLE: Flush wins
    @(negedge clk);
    md_op    = MUL;
    md_a     = 32'd3;
    md_b     = 32'd4;
    md_start = 1'b1;
    md_flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    md_flush = 1'b0;
    check("start_flush_busy", 32'(md_busy), 32'd0);
    check("start_flush_state", 32'(dut_state), 32'(MD_IDLE));
    repeat (W + 4) @(negedge clk);

    run_op(vecs[12], 3);
    run_op(vecs[0], 0);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
